// File: rtl/cpu_mem_arbiter.sv
// Arbitrates CPU instruction-fetch and data accesses onto a single shared bus.
// The data access goes first; the core is stalled until both accesses finish.
module cpu_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        im_read_mem,
  input  logic [31:0] im_addr,
  input  logic [2:0]  im_core_type,
  output logic [31:0] im_dataout,
  input  logic        dm_read_mem,
  input  logic        dm_write_mem,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_datain,
  input  logic [2:0]  dm_core_type,
  output logic [31:0] dm_dataout,
  output logic        cpu_stall,
  output logic        bus_req,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [2:0]  bus_size,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DM_ACC = 2'd1,
    IM_ACC = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_im_q, pend_im_d;
  logic [AW-1:0]   im_addr_q, im_addr_d;
  logic [SW-1:0]   im_size_q, im_size_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_write_q, bus_write_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic [SW-1:0]   bus_size_q, bus_size_d;
  logic [DW-1:0]   im_dataout_q, im_dataout_d;
  logic [DW-1:0]   dm_dataout_q, dm_dataout_d;
  logic            bus_err_q, bus_err_d;

  logic req_pending;
  logic dm_pending;
  logic timed_out;
  logic acc_done;

  assign req_pending = im_read_mem | dm_read_mem | dm_write_mem;
  assign dm_pending  = dm_read_mem | dm_write_mem;
  // bus_req_q low marks the one-cycle gap between the DM and IM accesses
  assign timed_out   = bus_req_q & ~bus_ack & (cnt_q == CW'(TIMEOUT));
  assign acc_done    = bus_req_q & (bus_ack | timed_out);

  // Next-state, bus drive and completion capture
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_im_d    = pend_im_q;
    im_addr_d    = im_addr_q;
    im_size_d    = im_size_q;
    bus_req_d    = bus_req_q;
    bus_write_d  = bus_write_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_size_d   = bus_size_q;
    im_dataout_d = im_dataout_q;
    dm_dataout_d = dm_dataout_q;
    bus_err_d    = bus_err_q;
    cpu_stall    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_pending) begin
          cpu_stall = 1'b1;
          pend_im_d = im_read_mem;
          im_addr_d = im_addr;
          im_size_d = im_core_type;
          bus_req_d = 1'b1;
          cnt_d     = '0;
          if (dm_pending) begin
            state_d     = DM_ACC;
            bus_write_d = dm_write_mem;
            bus_addr_d  = dm_addr;
            bus_wdata_d = dm_datain;
            bus_size_d  = dm_core_type;
          end else begin
            state_d     = IM_ACC;
            bus_write_d = 1'b0;
            bus_addr_d  = im_addr;
            bus_wdata_d = '0;
            bus_size_d  = im_core_type;
          end
        end
      end

      DM_ACC: begin
        cpu_stall = 1'b1;
        if (acc_done) begin
          if (!bus_write_q) begin
            dm_dataout_d = timed_out ? '1 : bus_rdata;
          end
          if (timed_out) begin
            bus_err_d = 1'b1;
          end
          bus_req_d = 1'b0;
          cnt_d     = '0;
          if (pend_im_q) begin
            state_d     = IM_ACC;
            bus_write_d = 1'b0;
            bus_addr_d  = im_addr_q;
            bus_wdata_d = '0;
            bus_size_d  = im_size_q;
          end else begin
            state_d = DONE;
          end
        end else if (bus_req_q) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      IM_ACC: begin
        cpu_stall = 1'b1;
        if (!bus_req_q) begin
          bus_req_d = 1'b1;
        end else if (acc_done) begin
          im_dataout_d = timed_out ? '1 : bus_rdata;
          if (timed_out) begin
            bus_err_d = 1'b1;
          end
          bus_req_d = 1'b0;
          pend_im_d = 1'b0;
          cnt_d     = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_im_q    <= 1'b0;
      im_addr_q    <= '0;
      im_size_q    <= '0;
      bus_req_q    <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_size_q   <= '0;
      im_dataout_q <= '0;
      dm_dataout_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_im_q    <= pend_im_d;
      im_addr_q    <= im_addr_d;
      im_size_q    <= im_size_d;
      bus_req_q    <= bus_req_d;
      bus_write_q  <= bus_write_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_size_q   <= bus_size_d;
      im_dataout_q <= im_dataout_d;
      dm_dataout_q <= dm_dataout_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_write  = bus_write_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_size   = bus_size_q;
  assign im_dataout = im_dataout_q;
  assign dm_dataout = dm_dataout_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: fetch, load+fetch priority, store,
// requests during DONE, timeout abort and asynchronous reset mid-access.
module tb_cpu_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        im_read_mem;
  logic [31:0] im_addr;
  logic [2:0]  im_core_type;
  logic [31:0] im_dataout;
  logic        dm_read_mem;
  logic        dm_write_mem;
  logic [31:0] dm_addr;
  logic [31:0] dm_datain;
  logic [2:0]  dm_core_type;
  logic [31:0] dm_dataout;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [2:0]  bus_size;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  cpu_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .im_read_mem  (im_read_mem),
    .im_addr      (im_addr),
    .im_core_type (im_core_type),
    .im_dataout   (im_dataout),
    .dm_read_mem  (dm_read_mem),
    .dm_write_mem (dm_write_mem),
    .dm_addr      (dm_addr),
    .dm_datain    (dm_datain),
    .dm_core_type (dm_core_type),
    .dm_dataout   (dm_dataout),
    .cpu_stall    (cpu_stall),
    .bus_req      (bus_req),
    .bus_write    (bus_write),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_size     (bus_size),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    im_read_mem = 1'b0; im_addr = '0; im_core_type = '0;
    dm_read_mem = 1'b0; dm_write_mem = 1'b0; dm_addr = '0;
    dm_datain = '0; dm_core_type = '0;
    bus_ack = 1'b0; bus_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_im_dataout", im_dataout, 32'h0);
    chk("rst_dm_dataout", dm_dataout, 32'h0);
    chk("rst_bus_req",    32'(bus_req), 32'h0);
    chk("rst_cpu_stall",  32'(cpu_stall), 32'h0);
    chk("rst_bus_err",    32'(bus_err), 32'h0);
    chk("rst_bus_addr",   bus_addr, 32'h0);
    rst = 1'b0;
    cyc();

    // IM-only fetch, ack on third wait cycle
    im_read_mem = 1'b1; im_addr = 32'h10; im_core_type = 3'd2; #1;
    chk("t1_idle_stall", 32'(cpu_stall), 32'h1);
    cyc(); im_read_mem = 1'b0; #1;
    chk("t1_c1_stall",   32'(cpu_stall), 32'h1);
    chk("t1_c1_req",     32'(bus_req), 32'h1);
    chk("t1_c1_addr",    bus_addr, 32'h10);
    chk("t1_c1_write",   32'(bus_write), 32'h0);
    chk("t1_c1_size",    32'(bus_size), 32'h2);
    cyc(); #1;
    chk("t1_c2_stall",   32'(cpu_stall), 32'h1);
    cyc(); bus_ack = 1'b1; bus_rdata = 32'h0050_0093; #1;
    chk("t1_c3_stall",   32'(cpu_stall), 32'h1);
    cyc(); bus_ack = 1'b0; #1;
    chk("t1_done_stall", 32'(cpu_stall), 32'h0);
    chk("t1_done_req",   32'(bus_req), 32'h0);
    chk("t1_im_data",    im_dataout, 32'h0050_0093);
    cyc();

    // Simultaneous DM load and IM fetch: DM first, one idle bus cycle, then IM
    dm_read_mem = 1'b1; dm_addr = 32'h8000; dm_core_type = 3'd2;
    im_read_mem = 1'b1; im_addr = 32'h14; im_core_type = 3'd2; #1;
    chk("t2_idle_stall", 32'(cpu_stall), 32'h1);
    cyc(); dm_read_mem = 1'b0; im_read_mem = 1'b0; #1;
    chk("t2_dm_req",     32'(bus_req), 32'h1);
    chk("t2_dm_addr",    bus_addr, 32'h8000);
    chk("t2_dm_write",   32'(bus_write), 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    cyc(); bus_ack = 1'b0; #1;
    chk("t2_gap_req",    32'(bus_req), 32'h0);
    chk("t2_gap_stall",  32'(cpu_stall), 32'h1);
    chk("t2_dm_data",    dm_dataout, 32'h1111_2222);
    cyc(); #1;
    chk("t2_im_req",     32'(bus_req), 32'h1);
    chk("t2_im_addr",    bus_addr, 32'h14);
    chk("t2_im_write",   32'(bus_write), 32'h0);
    chk("t2_im_wdata",   bus_wdata, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h3333_4444;
    cyc(); bus_ack = 1'b0; #1;
    chk("t2_done_stall", 32'(cpu_stall), 32'h0);
    chk("t2_im_data",    im_dataout, 32'h3333_4444);
    chk("t2_dm_hold",    dm_dataout, 32'h1111_2222);
    cyc();

    // DM store with read also asserted: treated as write, load data untouched
    dm_read_mem = 1'b1; dm_write_mem = 1'b1; dm_addr = 32'h8004;
    dm_datain = 32'hCAFE_BABE; dm_core_type = 3'd2; #1;
    cyc(); dm_read_mem = 1'b0; dm_write_mem = 1'b0; #1;
    chk("t3_req",        32'(bus_req), 32'h1);
    chk("t3_write",      32'(bus_write), 32'h1);
    chk("t3_wdata",      bus_wdata, 32'hCAFE_BABE);
    chk("t3_size",       32'(bus_size), 32'h2);
    chk("t3_addr",       bus_addr, 32'h8004);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_DEAD;
    cyc(); bus_ack = 1'b0; #1;
    chk("t3_dm_hold",    dm_dataout, 32'h1111_2222);
    chk("t3_im_hold",    im_dataout, 32'h3333_4444);
    cyc();

    // Request and stray ack during DONE are ignored; request taken in next IDLE
    im_read_mem = 1'b1; im_addr = 32'h18; im_core_type = 3'd2; #1;
    cyc(); im_read_mem = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0000_0055; #1;
    cyc(); dm_read_mem = 1'b1; dm_addr = 32'h8008; dm_core_type = 3'd2;
    bus_ack = 1'b1; bus_rdata = 32'h9999_9999; #1;
    chk("t4_done_stall", 32'(cpu_stall), 32'h0);
    chk("t4_im_data",    im_dataout, 32'h0000_0055);
    cyc(); bus_ack = 1'b0; #1;
    chk("t4_idle_stall", 32'(cpu_stall), 32'h1);
    chk("t4_idle_req",   32'(bus_req), 32'h0);
    chk("t4_dm_noack",   dm_dataout, 32'h1111_2222);
    cyc(); dm_read_mem = 1'b0; #1;
    chk("t4_dm_req",     32'(bus_req), 32'h1);
    chk("t4_dm_addr",    bus_addr, 32'h8008);
    bus_ack = 1'b1; bus_rdata = 32'h7777_8888;
    cyc(); bus_ack = 1'b0; #1;
    chk("t4_dm_data",    dm_dataout, 32'h7777_8888);
    cyc();

    // DM read timeout: counter 0..3 over four waits, abort when it reads 4
    dm_read_mem = 1'b1; dm_addr = 32'h800C; dm_core_type = 3'd2; #1;
    cyc(); dm_read_mem = 1'b0; #1;
    chk("t5_c1_req",     32'(bus_req), 32'h1);
    repeat (4) cyc();
    chk("t5_c5_req",     32'(bus_req), 32'h1);
    chk("t5_c5_err",     32'(bus_err), 32'h0);
    cyc(); #1;
    chk("t5_done_req",   32'(bus_req), 32'h0);
    chk("t5_done_stall", 32'(cpu_stall), 32'h0);
    chk("t5_dm_data",    dm_dataout, 32'hFFFF_FFFF);
    chk("t5_err",        32'(bus_err), 32'h1);
    cyc();
    im_read_mem = 1'b1; im_addr = 32'h1C; im_core_type = 3'd2; #1;
    cyc(); im_read_mem = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0000_ABCD; #1;
    cyc(); bus_ack = 1'b0; #1;
    chk("t5_im_data",    im_dataout, 32'h0000_ABCD);
    chk("t5_err_sticky", 32'(bus_err), 32'h1);
    cyc();

    // Asynchronous reset in the middle of a DM access
    dm_write_mem = 1'b1; dm_addr = 32'h8010; dm_datain = 32'h1234_5678;
    dm_core_type = 3'd2; #1;
    cyc(); dm_write_mem = 1'b0; #1;
    chk("t6_pre_req",    32'(bus_req), 32'h1);
    #2; rst = 1'b1; #1;
    chk("t6_rst_req",    32'(bus_req), 32'h0);
    chk("t6_rst_stall",  32'(cpu_stall), 32'h0);
    chk("t6_rst_err",    32'(bus_err), 32'h0);
    chk("t6_rst_write",  32'(bus_write), 32'h0);
    chk("t6_rst_addr",   bus_addr, 32'h0);
    chk("t6_rst_wdata",  bus_wdata, 32'h0);
    chk("t6_rst_size",   32'(bus_size), 32'h0);
    chk("t6_rst_dm",     dm_dataout, 32'h0);
    chk("t6_rst_im",     im_dataout, 32'h0);
    #2; rst = 1'b0;
    cyc();
    dm_read_mem = 1'b1; dm_addr = 32'h8014; dm_core_type = 3'd1; #1;
    chk("t6_idle_stall", 32'(cpu_stall), 32'h1);
    cyc(); dm_read_mem = 1'b0; #1;
    chk("t6_req",        32'(bus_req), 32'h1);
    chk("t6_addr",       bus_addr, 32'h8014);
    chk("t6_size",       32'(bus_size), 32'h1);
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    cyc(); bus_ack = 1'b0; #1;
    chk("t6_dm_data",    dm_dataout, 32'h0BAD_F00D);
    chk("t6_err",        32'(bus_err), 32'h0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
